cancid_stream_ctx: RTL and testbench

- Parametrised per-stream context manager for one DPI regex category engine.
- Saves and restores engine DFA state per stream ID across packets.
- Holds a saturating per-stream match counter and a global match counter.
- Sits between the packet parser (sop/eop/stream_id) and an external regex engine. Unlike the single-counter wrapper, engine state width, stream count and counter width are all parameters.

---
 rtl/cancid_stream_ctx.sv | 215 +++++++++++++++++++++
 tb/tb_cancid_stream_ctx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cancid_stream_ctx.sv
// Per-stream DFA context save/restore and match counting for one regex category engine.
// Optional clear sweep (clear_req/busy) is built only when CANCID_CTX_CLEAR_EN is defined.
//
// state  | meaning
// IDLE   | no packet in flight
// LOAD   | restored engine state presented for one cycle
// ACTIVE | engine consuming packet bytes; eop commits
module cancid_stream_ctx #(
  parameter int STATE_W     = 11,
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sop,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               new_stream_id,
  input  logic               enable,
  input  logic               eop,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_in_vld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic               match,
  output logic               fired,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   total_count,
`ifdef CANCID_CTX_CLEAR_EN
  input  logic               clear_req,
`endif
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         state_q, state_d;
  logic [SID_W-1:0]   cur_sid_q, cur_sid_d;
  logic               cur_en_q, cur_en_d;
  logic               cur_new_q, cur_new_d;
  logic               match_q, match_d;
  logic               fired_q, fired_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;

  logic [STATE_W-1:0] state_mem [NUM_STREAMS];
  logic [CNT_W-1:0]   cnt_q [NUM_STREAMS];

  logic               mem_we;
  logic [SID_W-1:0]   mem_waddr;
  logic [STATE_W-1:0] mem_wdata;
  logic               cnt_we;
  logic [SID_W-1:0]   cnt_waddr;
  logic [CNT_W-1:0]   cnt_wdata;
  logic               start_load;
  logic               commit;
  logic               hit;
  logic               sweep_block;

`ifdef CANCID_CTX_CLEAR_EN
  logic               busy_q, busy_d;
  logic [SID_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic               sweep_start;

  // The FSM is parked in IDLE for the whole sweep, so commits never collide with it.
  assign sweep_start = clear_req && (state_q == S_IDLE) && !busy_q;
  assign sweep_block = busy_q || sweep_start;
  assign busy        = busy_q;

  always_comb begin
    busy_d      = busy_q;
    sweep_idx_d = sweep_idx_q;
    if (sweep_start) begin
      busy_d      = 1'b1;
      sweep_idx_d = '0;
    end else if (busy_q) begin
      sweep_idx_d = sweep_idx_q + SID_W'(1);
      if (sweep_idx_q == SID_W'(NUM_STREAMS - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      sweep_idx_q <= '0;
    end else begin
      busy_q      <= busy_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end
`else
  assign sweep_block = 1'b0;
  assign busy        = 1'b0;
`endif

  assign hit = match_q || eng_accept;

  always_comb begin
    state_d    = state_q;
    cur_sid_d  = cur_sid_q;
    cur_en_d   = cur_en_q;
    cur_new_d  = cur_new_q;
    match_d    = match_q;
    fired_d    = 1'b0;
    total_d    = total_q;
    start_load = 1'b0;
    commit     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cur_sid_q;
    mem_wdata  = eng_state_out;
    cnt_we     = 1'b0;
    cnt_waddr  = cur_sid_q;
    cnt_wdata  = cnt_q[cur_sid_q] + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (sop && !sweep_block) start_load = 1'b1;
      end
      S_LOAD: begin
        state_d = S_ACTIVE;
        if (eng_accept) match_d = 1'b1;
      end
      S_ACTIVE: begin
        if (eng_accept) match_d = 1'b1;
        if (eop) begin
          commit  = 1'b1;
          match_d = 1'b0;
          state_d = S_IDLE;
        end
        if (sop) start_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // sop without eop in ACTIVE lands here without commit: the old packet is aborted.
    if (start_load) begin
      state_d   = S_LOAD;
      cur_sid_d = stream_id;
      cur_en_d  = enable;
      cur_new_d = new_stream_id;
      match_d   = 1'b0;
    end

    if (commit && cur_en_q) begin
      mem_we = 1'b1;
      if (hit) begin
        fired_d = 1'b1;
        cnt_we  = (cnt_q[cur_sid_q] != CNT_MAX);
        if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
      end
    end

`ifdef CANCID_CTX_CLEAR_EN
    if (busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_idx_q;
      mem_wdata = '0;
      cnt_we    = 1'b1;
      cnt_waddr = sweep_idx_q;
      cnt_wdata = '0;
      if (sweep_idx_q == '0) total_d = '0;
    end
`endif

    // Sampled before this edge's counter write, so a same-sid read sees the old value.
    rd_count_d = cnt_q[rd_sid];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_sid_q  <= '0;
      cur_en_q   <= 1'b0;
      cur_new_q  <= 1'b0;
      match_q    <= 1'b0;
      fired_q    <= 1'b0;
      total_q    <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_sid_q  <= cur_sid_d;
      cur_en_q   <= cur_en_d;
      cur_new_q  <= cur_new_d;
      match_q    <= match_d;
      fired_q    <= fired_d;
      total_q    <= total_d;
      rd_count_q <= rd_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) cnt_q[i] <= '0;
    end else if (cnt_we) begin
      cnt_q[cnt_waddr] <= cnt_wdata;
    end
  end

  // State RAM is deliberately not reset; new_stream_id masks stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) state_mem[mem_waddr] <= mem_wdata;
  end

  assign eng_state_in_vld = (state_q == S_LOAD);
  assign eng_state_in     = (state_q == S_LOAD && !cur_new_q) ? state_mem[cur_sid_q] : '0;
  assign match            = match_q;
  assign fired            = fired_q;
  assign rd_count         = rd_count_q;
  assign total_count      = total_q;

endmodule

// File: tb/tb_cancid_stream_ctx.sv
// Directed bench for cancid_stream_ctx built with CNT_W=4 so saturation is reachable.
// Exercises the clear sweep too when CANCID_CTX_CLEAR_EN is defined.
module tb_cancid_stream_ctx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sop;
  logic [5:0]  stream_id;
  logic        new_stream_id;
  logic        enable;
  logic        eop;
  logic [10:0] eng_state_in;
  logic        eng_state_in_vld;
  logic [10:0] eng_state_out;
  logic        eng_accept;
  logic        match;
  logic        fired;
  logic [5:0]  rd_sid;
  logic [3:0]  rd_count;
  logic [3:0]  total_count;
  logic        busy;
`ifdef CANCID_CTX_CLEAR_EN
  logic        clear_req;
`endif

  int checks = 0;
  int errors = 0;

  cancid_stream_ctx #(
    .STATE_W(11), .NUM_STREAMS(64), .SID_W(6), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .sop(sop), .stream_id(stream_id),
    .new_stream_id(new_stream_id), .enable(enable), .eop(eop),
    .eng_state_in(eng_state_in), .eng_state_in_vld(eng_state_in_vld),
    .eng_state_out(eng_state_out), .eng_accept(eng_accept),
    .match(match), .fired(fired), .rd_sid(rd_sid), .rd_count(rd_count),
    .total_count(total_count),
`ifdef CANCID_CTX_CLEAR_EN
    .clear_req(clear_req),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full packet; returns what the LOAD cycle presented to the engine.
  task automatic packet(input logic [5:0] sid, input logic nw, input logic en,
                        input logic acc_mid, input logic acc_eop, input logic [10:0] st_out,
                        output logic ld_vld, output logic [10:0] ld_val);
    sop = 1'b1; stream_id = sid; new_stream_id = nw; enable = en;
    tick();
    sop = 1'b0;
    ld_vld = eng_state_in_vld;
    ld_val = eng_state_in;
    tick();
    if (acc_mid) begin
      eng_accept = 1'b1;
      tick();
      eng_accept = 1'b0;
    end
    eop = 1'b1; eng_accept = acc_eop; eng_state_out = st_out;
    tick();
    eop = 1'b0; eng_accept = 1'b0;
  endtask

  logic        lv;
  logic [10:0] ld;
  int          nbusy;
  logic        vld_seen;

  initial begin
    rst = 1'b1; sop = 1'b0; stream_id = '0; new_stream_id = 1'b0; enable = 1'b0;
    eop = 1'b0; eng_state_out = '0; eng_accept = 1'b0; rd_sid = '0;
`ifdef CANCID_CTX_CLEAR_EN
    clear_req = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_vld", eng_state_in_vld, 0);
    chk("rst_state_in", eng_state_in, 0);
    chk("rst_match", match, 0);
    chk("rst_fired", fired, 0);
    chk("rst_total", total_count, 0);
    chk("rst_rdcount", rd_count, 0);
    chk("rst_busy", busy, 0);

    // sid 5: new stream, accept, commit
    sop = 1'b1; stream_id = 6'd5; new_stream_id = 1'b1; enable = 1'b1;
    tick();
    sop = 1'b0;
    chk("s5_vld", eng_state_in_vld, 1);
    chk("s5_state_in", eng_state_in, 0);
    tick();
    chk("s5_vld_drop", eng_state_in_vld, 0);
    eng_accept = 1'b1;
    tick();
    eng_accept = 1'b0;
    chk("s5_match", match, 1);
    eop = 1'b1; eng_state_out = 11'h011;
    tick();
    eop = 1'b0;
    chk("s5_fired", fired, 1);
    chk("s5_total", total_count, 1);
    chk("s5_match_clr", match, 0);
    rd_sid = 6'd5;
    tick();
    chk("s5_fired_pulse", fired, 0);
    chk("s5_rdcount", rd_count, 1);

    // accept and eop in IDLE are ignored
    eng_accept = 1'b1; eop = 1'b1;
    tick();
    eng_accept = 1'b0; eop = 1'b0;
    chk("idle_match", match, 0);
    chk("idle_fired", fired, 0);
    chk("idle_total", total_count, 1);

    // sid 3 state save and restore
    packet(6'd3, 1'b1, 1'b1, 1'b0, 1'b0, 11'h2A5, lv, ld);
    chk("s3_fired", fired, 0);
    packet(6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 11'h2A5, lv, ld);
    chk("s3_vld", lv, 1);
    chk("s3_restore", ld, 11'h2A5);
    packet(6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 11'h011, lv, ld);
    chk("s5_restore", ld, 11'h011);

    // sid 7 disabled packet leaves state and counters alone
    packet(6'd7, 1'b1, 1'b1, 1'b0, 1'b0, 11'h123, lv, ld);
    packet(6'd7, 1'b0, 1'b0, 1'b1, 1'b0, 11'h456, lv, ld);
    chk("s7_load", ld, 11'h123);
    chk("s7_fired", fired, 0);
    chk("s7_match", match, 0);
    chk("s7_total", total_count, 1);
    rd_sid = 6'd7;
    tick();
    chk("s7_rdcount", rd_count, 0);
    packet(6'd7, 1'b0, 1'b1, 1'b0, 1'b0, 11'h123, lv, ld);
    chk("s7_state_kept", ld, 11'h123);

    // accept only in the eop cycle
    packet(6'd4, 1'b1, 1'b1, 1'b0, 1'b1, 11'h004, lv, ld);
    chk("eopacc_fired", fired, 1);
    chk("eopacc_total", total_count, 2);

    // sop+eop in one cycle: commit sid 2, load sid 9
    sop = 1'b1; stream_id = 6'd2; new_stream_id = 1'b1; enable = 1'b1;
    tick();
    sop = 1'b0;
    tick();
    eng_accept = 1'b1;
    tick();
    eng_accept = 1'b0;
    sop = 1'b1; stream_id = 6'd9; eop = 1'b1; eng_state_out = 11'h0AB;
    tick();
    sop = 1'b0; eop = 1'b0;
    chk("se_fired", fired, 1);
    chk("se_vld", eng_state_in_vld, 1);
    chk("se_state_in", eng_state_in, 0);
    chk("se_match", match, 0);
    chk("se_total", total_count, 3);
    tick();
    eng_accept = 1'b1;
    tick();
    eng_accept = 1'b0;
    chk("s9_match", match, 1);

    // abort sid 9 with sop and no eop
    sop = 1'b1; stream_id = 6'd11;
    tick();
    sop = 1'b0;
    chk("abort_fired", fired, 0);
    chk("abort_vld", eng_state_in_vld, 1);
    chk("abort_match", match, 0);
    tick();
    eop = 1'b1; eng_state_out = 11'h00B;
    tick();
    eop = 1'b0;
    chk("s11_fired", fired, 0);
    chk("abort_total", total_count, 3);
    rd_sid = 6'd9;
    tick();
    chk("s9_rdcount", rd_count, 0);
    rd_sid = 6'd2;
    tick();
    chk("s2_rdcount", rd_count, 1);
    packet(6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0AB, lv, ld);
    chk("s2_restore", ld, 11'h0AB);

    // read and commit on the same sid return the pre-commit count
    rd_sid = 6'd4;
    packet(6'd4, 1'b0, 1'b1, 1'b1, 1'b0, 11'h004, lv, ld);
    chk("rdw_pre", rd_count, 1);
    tick();
    chk("rdw_post", rd_count, 2);
    chk("rdw_total", total_count, 4);

    // saturation at 15 with CNT_W=4
    rd_sid = 6'd1;
    for (int i = 0; i < 20; i++) begin
      packet(6'd1, (i == 0), 1'b1, 1'b1, 1'b0, 11'h001, lv, ld);
      if (i == 10) chk("sat_total_at15", total_count, 15);
    end
    chk("sat_fired", fired, 1);
    tick();
    chk("sat_rdcount", rd_count, 15);
    chk("sat_total", total_count, 15);

`ifdef CANCID_CTX_CLEAR_EN
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    sop = 1'b1; stream_id = 6'd3; new_stream_id = 1'b0; enable = 1'b1;
    nbusy = 0; vld_seen = 1'b0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      tick();
      if (eng_state_in_vld === 1'b1) vld_seen = 1'b1;
    end
    sop = 1'b0;
    chk("clr_busy_len", nbusy, 64);
    chk("clr_sop_dropped", vld_seen, 0);
    chk("clr_total", total_count, 0);
    rd_sid = 6'd1;
    tick();
    chk("clr_rd1", rd_count, 0);
    rd_sid = 6'd4;
    tick();
    chk("clr_rd4", rd_count, 0);
    packet(6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, lv, ld);
    chk("clr_state3", ld, 0);
`else
    chk("busy_tied", busy, 0);
`endif

    // reset mid-packet discards the packet
    sop = 1'b1; stream_id = 6'd12; new_stream_id = 1'b1; enable = 1'b1;
    tick();
    sop = 1'b0;
    tick();
    eng_accept = 1'b1;
    tick();
    eng_accept = 1'b0;
    rst = 1'b1; eop = 1'b1;
    tick();
    rst = 1'b0; eop = 1'b0;
    chk("mrst_match", match, 0);
    chk("mrst_fired", fired, 0);
    chk("mrst_total", total_count, 0);
    rd_sid = 6'd12;
    tick();
    chk("mrst_rd12", rd_count, 0);
    chk("mrst_fired2", fired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
